// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command arbiter (init pass-through, then refresh > write > read grants); define ARBIT_RR_EN for write/read round-robin
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 13,
    parameter int         DATA_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              a_ref_req,
    input  logic              a_ref_end,
    input  logic [3:0]        a_ref_cmd,
    input  logic [1:0]        a_ref_ba,
    input  logic [ADDR_W-1:0] a_ref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sdram_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              a_ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);
    typedef enum logic [2:0] {IDLE, ARBIT, A_REF, WRITE, READ} state_t;
    state_t            r_state;
    logic              r_a_ref_en, r_wr_en, r_rd_en;
    logic              w_wr_win;
    logic [3:0]        w_cmd;
    logic [1:0]        w_ba;
    logic [ADDR_W-1:0] w_addr;
`ifdef ARBIT_RR_EN
    logic r_rd_last;
    // remember whether read (1) or write (0) took the most recent data grant
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            r_rd_last <= 1'b1;
        else if (r_state == ARBIT && !a_ref_req && (wr_req || rd_req))
            r_rd_last <= !w_wr_win;
    end
    assign w_wr_win = wr_req && (!rd_req || r_rd_last);
`else
    assign w_wr_win = wr_req;
`endif
    // grant FSM: refresh first, then write/read; enables registered alongside state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_a_ref_en <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
        end else begin
            case (r_state)
                IDLE:  if (init_end) r_state <= ARBIT;
                ARBIT: begin
                    if (a_ref_req) begin
                        r_state    <= A_REF;
                        r_a_ref_en <= 1'b1;
                    end else if (w_wr_win) begin
                        r_state <= WRITE;
                        r_wr_en <= 1'b1;
                    end else if (rd_req) begin
                        r_state <= READ;
                        r_rd_en <= 1'b1;
                    end
                end
                A_REF: if (a_ref_end) begin
                    r_state    <= ARBIT;
                    r_a_ref_en <= 1'b0;
                end
                WRITE: if (wr_end) begin
                    r_state <= ARBIT;
                    r_wr_en <= 1'b0;
                end
                READ:  if (rd_end) begin
                    r_state <= ARBIT;
                    r_rd_en <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // pin mux follows the current owner directly from state
    always_comb begin
        w_cmd  = (r_state == A_REF) ? a_ref_cmd  : (r_state == WRITE) ? wr_cmd  : (r_state == READ) ? rd_cmd  : (r_state == ARBIT) ? CMD_NOP : init_cmd;
        w_ba   = (r_state == A_REF) ? a_ref_ba   : (r_state == WRITE) ? wr_ba   : (r_state == READ) ? rd_ba   : (r_state == ARBIT) ? 2'b11   : init_ba;
        w_addr = (r_state == A_REF) ? a_ref_addr : (r_state == WRITE) ? wr_addr : (r_state == READ) ? rd_addr : (r_state == ARBIT) ? '1      : init_addr;
    end
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_ba     = w_ba;
    assign sdram_addr   = w_addr;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = wr_sdram_en && (r_state == WRITE);
    assign a_ref_en     = r_a_ref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed-vector bench for sdram_arbit (expectations follow ARBIT_RR_EN when defined)
module tb_sdram_arbit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  init_cmd = 4'b0010, a_ref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
    logic [1:0]  init_ba = 2'd0, a_ref_ba = 2'd1, wr_ba = 2'd2, rd_ba = 2'd1;
    logic [12:0] init_addr = 13'h0400, a_ref_addr = 13'h0011, wr_addr = 13'h0123, rd_addr = 13'h0456;
    logic        init_end = 0, a_ref_req = 0, a_ref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_sdram_en = 0;
    logic        a_ref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_out;
    int          n_vec = 0, n_err = 0;
    int          cur;
    int          exp_seq [3];

    sdram_arbit dut (
        .sys_clk(clk), .sys_rst(rst),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
        .a_ref_req(a_ref_req), .a_ref_end(a_ref_end), .a_ref_cmd(a_ref_cmd), .a_ref_ba(a_ref_ba), .a_ref_addr(a_ref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_sdram_en(wr_sdram_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .a_ref_en(a_ref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(cke),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_ba(ba), .sdram_addr(addr), .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        chk({tag, "_cmd"}, {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, c});
        chk({tag, "_ba"}, {30'd0, ba}, {30'd0, b});
        chk({tag, "_addr"}, {19'd0, addr}, {19'd0, a});
    endtask

    task automatic chk_en(input string tag, input logic [2:0] e);
        chk({tag, "_en"}, {29'd0, a_ref_en, wr_en, rd_en}, {29'd0, e});
    endtask

    initial begin
`ifdef ARBIT_RR_EN
        exp_seq = '{1, 0, 1};
`else
        exp_seq = '{0, 0, 0};
`endif
        repeat (3) step();
        chk_bus("reset", 4'b0010, 2'd0, 13'h0400);
        chk_en("reset", 3'b000);
        chk("reset_oe", {31'd0, dq_oe}, 32'd0);
        chk("reset_cke", {31'd0, cke}, 32'd1);
        rst = 0;
        step();
        chk_bus("idle_hold", 4'b0010, 2'd0, 13'h0400);
        init_end = 1;
        step();
        chk_bus("arbit", 4'b0111, 2'd3, 13'h1FFF);
        chk_en("arbit", 3'b000);
        step();
        chk_en("arbit_noreq", 3'b000);
        a_ref_req = 1; wr_req = 1; rd_req = 1;
        step();
        chk_en("aref_grant", 3'b100);
        chk_bus("aref", 4'b0001, 2'd1, 13'h0011);
        a_ref_req = 0;
        step();
        chk_en("aref_hold", 3'b100);
        a_ref_end = 1;
        step();
        a_ref_end = 0;
        chk_en("aref_done", 3'b000);
        chk_bus("aref_nop", 4'b0111, 2'd3, 13'h1FFF);
        wr_sdram_en = 1; wr_data = 16'hA5A5;
        step();
        chk_en("grant0", 3'b010);
        chk_bus("write", 4'b0100, 2'd2, 13'h0123);
        chk("wr_oe", {31'd0, dq_oe}, 32'd1);
        chk("wr_dq", {16'd0, dq_out}, 32'h0000A5A5);
        cur = 0;
        for (int i = 0; i < 3; i++) begin
            if (cur == 0) wr_end = 1; else rd_end = 1;
            step();
            wr_end = 0; rd_end = 0;
            chk_en($sformatf("gap%0d", i), 3'b000);
            step();
            cur = exp_seq[i];
            chk_en($sformatf("grant%0d", i + 1), cur == 0 ? 3'b010 : 3'b001);
        end
        wr_req = 0;
        if (cur == 0) wr_end = 1; else rd_end = 1;
        step();
        wr_end = 0; rd_end = 0;
        step();
        chk_en("read", 3'b001);
        chk_bus("read", 4'b0101, 2'd1, 13'h0456);
        chk("rd_oe", {31'd0, dq_oe}, 32'd0);
        wr_end = 1;
        step();
        wr_end = 0;
        chk_en("rd_ignore_wr_end", 3'b001);
        rst = 1;
        step();
        rst = 0; rd_req = 0;
        chk_en("rst_mid", 3'b000);
        chk_bus("rst_mid", 4'b0010, 2'd0, 13'h0400);
        step();
        chk_bus("rearbit", 4'b0111, 2'd3, 13'h1FFF);
        init_end = 0;
        step();
        chk_bus("init_fall", 4'b0111, 2'd3, 13'h1FFF);
        chk_en("init_fall", 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
